// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate enable from the system clock, h/v counters
// over the full frame, and registered sync, visible-area and wrap strobes.
module vga_timing_gen #(
  parameter int DIV   = 4,
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);

  function automatic logic in_win(input logic [9:0] c, input int lo, input int hi);
    int ci;
    ci = int'(c);
    return (ci >= lo) && (ci < hi);
  endfunction

  logic [PW-1:0] presc_q;
  logic          h_last;
  logic          v_last;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;

  // Tick gated by rst so that DIV=1 (tick == en) still stays quiet during reset.
  always_comb begin
    pix_tick = en & ~rst & (presc_q == PRE_LAST);
  end

  always_comb begin
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
    h_nxt  = h_last ? '0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_last) begin
      v_nxt = v_last ? '0 : v_cnt + 10'd1;
    end
  end

  // Prescaler: a dropped enable discards partial progress on the current pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (!en || (presc_q == PRE_LAST)) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Counter stage: sync/valid are decoded from the next counter values so they
  // land on the same edge as the counters they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      valid       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_tick & h_last;
      frame_start <= pix_tick & h_last & v_last;
      if (pix_tick) begin
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        hsync <= ~in_win(h_nxt, H_VIS + H_FP, H_VIS + H_FP + H_SW);
        vsync <= ~in_win(v_nxt, V_VIS + V_FP, V_VIS + V_FP + V_SW);
        valid <= in_win(h_nxt, 0, H_VIS) & in_win(v_nxt, 0, V_VIS);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: directed stimulus queues hand-computed expectations keyed by
// cycle; a monitor pops and compares them as the DUTs present their outputs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  bit   clk_on = 1'b0;
  int   cyc = 0;

  logic rst_a = 1'b0, en_a = 1'b0, rst_b = 1'b0, en_b = 1'b0;
  logic pt_a, hs_a, vs_a, val_a, ls_a, fs_a;
  logic pt_b, hs_b, vs_b, val_b, ls_b, fs_b;
  logic [9:0] h_a, v_a, h_b, v_b;

  // Full-size 640x480 raster.
  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pix_tick(pt_a), .h_cnt(h_a), .v_cnt(v_a),
    .hsync(hs_a), .vsync(vs_a), .valid(val_a), .line_start(ls_a), .frame_start(fs_a)
  );

  // Miniature raster (15x8, DIV=1) so frame wrap and vsync fit in a short run.
  vga_timing_gen #(
    .DIV(1), .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SW(2), .V_BP(1)
  ) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pix_tick(pt_b), .h_cnt(h_b), .v_cnt(v_b),
    .hsync(hs_b), .vsync(vs_b), .valid(val_b), .line_start(ls_b), .frame_start(fs_b)
  );

  initial begin
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  localparam int PT = 0, HC = 1, VC = 2, HS = 3, VS = 4, VAL = 5, LS = 6, FS = 7, B = 8;
  localparam int C_HSA = 16, C_LSA = 17, C_FSA = 18, C_VSB = 19, C_LSB = 20, C_FSB = 21;

  int hs_low_a = 0, ls_cnt_a = 0, fs_cnt_a = 0, vs_low_b = 0, ls_cnt_b = 0, fs_cnt_b = 0;

  always @(negedge clk) begin
    if (!rst_a && !hs_a) hs_low_a <= hs_low_a + 1;
    if (!rst_a && ls_a)  ls_cnt_a <= ls_cnt_a + 1;
    if (!rst_a && fs_a)  fs_cnt_a <= fs_cnt_a + 1;
    if (!rst_b && !vs_b) vs_low_b <= vs_low_b + 1;
    if (!rst_b && ls_b)  ls_cnt_b <= ls_cnt_b + 1;
    if (!rst_b && fs_b)  fs_cnt_b <= fs_cnt_b + 1;
  end

  function automatic int probe(input int sel);
    case (sel)
      PT:      return int'(pt_a);
      HC:      return int'(h_a);
      VC:      return int'(v_a);
      HS:      return int'(hs_a);
      VS:      return int'(vs_a);
      VAL:     return int'(val_a);
      LS:      return int'(ls_a);
      FS:      return int'(fs_a);
      B + PT:  return int'(pt_b);
      B + HC:  return int'(h_b);
      B + VC:  return int'(v_b);
      B + HS:  return int'(hs_b);
      B + VS:  return int'(vs_b);
      B + VAL: return int'(val_b);
      B + LS:  return int'(ls_b);
      B + FS:  return int'(fs_b);
      C_HSA:   return hs_low_a;
      C_LSA:   return ls_cnt_a;
      C_FSA:   return fs_cnt_a;
      C_VSB:   return vs_low_b;
      C_LSB:   return ls_cnt_b;
      C_FSB:   return fs_cnt_b;
      default: return -1;
    endcase
  endfunction

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  // Monitor: cyc == -1 entries are checked immediately when chk_ev fires.
  initial begin
    exp_t e;
    int   got;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0 && (sb[0].cyc == -1 || sb[0].cyc <= cyc)) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc >= 0 && e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: check for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
        end else begin
          got = probe(e.sel);
          if (got != e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, got, e.val, cyc);
          end
        end
      end
    end
  end

  task automatic ex(input int c, input int sel, input int val, input string name);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic fire();
    ->chk_ev;
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  int c0, d0, e0;

  initial begin
    // Reset with no clock running.
    #2 rst_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
    #3;
    ex(-1, PT, 0, "a_rst_pix_tick"); ex(-1, HC, 0, "a_rst_h");   ex(-1, VC, 0, "a_rst_v");
    ex(-1, HS, 1, "a_rst_hsync");    ex(-1, VS, 1, "a_rst_vsync"); ex(-1, VAL, 1, "a_rst_valid");
    ex(-1, LS, 0, "a_rst_line");     ex(-1, FS, 0, "a_rst_frame");
    ex(-1, B + PT, 0, "b_rst_pix_tick_en_high"); ex(-1, B + HC, 0, "b_rst_h");
    ex(-1, B + HS, 1, "b_rst_hsync");            ex(-1, B + VS, 1, "b_rst_vsync");
    fire();
    clk_on = 1'b1;

    // Full-size raster: pixel rate and one line.
    wait_cyc(2);
    rst_a = 1'b0; en_a = 1'b1; c0 = cyc;
    ex(c0, HC, 0, "a_first_h"); ex(c0, PT, 0, "a_first_tick"); ex(c0, LS, 0, "a_first_line");
    ex(c0, FS, 0, "a_first_frame"); ex(c0, VAL, 1, "a_first_valid");
    ex(c0 + 3, PT, 1, "a_tick_1"); ex(c0 + 3, HC, 0, "a_h_hold_0");
    ex(c0 + 4, PT, 0, "a_tick_gap"); ex(c0 + 4, HC, 1, "a_h_1");
    ex(c0 + 7, PT, 1, "a_tick_2"); ex(c0 + 8, HC, 2, "a_h_2");
    ex(c0 + 2556, HC, 639, "a_h_639"); ex(c0 + 2556, VAL, 1, "a_valid_639");
    ex(c0 + 2560, HC, 640, "a_h_640"); ex(c0 + 2560, VAL, 0, "a_valid_640");
    ex(c0 + 2620, HS, 1, "a_hsync_655");
    ex(c0 + 2624, HC, 656, "a_h_656"); ex(c0 + 2624, HS, 0, "a_hsync_656");
    ex(c0 + 3007, HC, 751, "a_h_751"); ex(c0 + 3007, HS, 0, "a_hsync_751");
    ex(c0 + 3008, HS, 1, "a_hsync_752");
    ex(c0 + 3199, HC, 799, "a_h_799"); ex(c0 + 3199, VC, 0, "a_v_0"); ex(c0 + 3199, LS, 0, "a_line_pre");
    ex(c0 + 3200, HC, 0, "a_wrap_h"); ex(c0 + 3200, VC, 1, "a_wrap_v");
    ex(c0 + 3200, LS, 1, "a_line_pulse"); ex(c0 + 3200, FS, 0, "a_no_frame");
    ex(c0 + 3200, VAL, 1, "a_valid_line1");
    ex(c0 + 3201, LS, 0, "a_line_end");

    // Enable drop for 37 clks while h_cnt = 100.
    wait_cyc(c0 + 3601);
    en_a = 1'b0;
    ex(c0 + 3620, HC, 100, "a_freeze_h"); ex(c0 + 3620, VC, 1, "a_freeze_v");
    ex(c0 + 3620, PT, 0, "a_freeze_tick"); ex(c0 + 3620, HS, 1, "a_freeze_hsync");
    ex(c0 + 3638, HC, 100, "a_freeze_end_h"); ex(c0 + 3638, PT, 0, "a_freeze_end_tick");
    ex(c0 + 3641, HC, 100, "a_resume_h100"); ex(c0 + 3641, PT, 1, "a_resume_tick");
    ex(c0 + 3642, HC, 101, "a_resume_h101"); ex(c0 + 3646, HC, 102, "a_resume_h102");
    ex(c0 + 6437, HC, 799, "a_l1_h799"); ex(c0 + 6437, LS, 0, "a_l1_line_pre");
    ex(c0 + 6438, HC, 0, "a_l1_wrap_h"); ex(c0 + 6438, VC, 2, "a_l1_wrap_v");
    ex(c0 + 6438, LS, 1, "a_l1_line_pulse"); ex(c0 + 6439, LS, 0, "a_l1_line_end");
    wait_cyc(c0 + 3638);
    en_a = 1'b1;
    drain();
    ex(-1, C_HSA, 768, "a_hsync_low_clks"); ex(-1, C_LSA, 2, "a_line_pulses");
    ex(-1, C_FSA, 0, "a_frame_pulses");
    fire();

    // Miniature raster: full frame.
    rst_b = 1'b0; d0 = cyc;
    ex(d0, B + PT, 1, "b_tick_div1"); ex(d0, B + HC, 0, "b_first_h"); ex(d0, B + VC, 0, "b_first_v");
    ex(d0, B + LS, 0, "b_first_line"); ex(d0, B + FS, 0, "b_first_frame");
    ex(d0, B + VAL, 1, "b_first_valid");
    ex(d0 + 1, B + HC, 1, "b_h_1");
    ex(d0 + 7, B + VAL, 1, "b_valid_h7"); ex(d0 + 8, B + VAL, 0, "b_valid_h8");
    ex(d0 + 9, B + HS, 1, "b_hsync_h9"); ex(d0 + 10, B + HS, 0, "b_hsync_h10");
    ex(d0 + 12, B + HS, 0, "b_hsync_h12"); ex(d0 + 13, B + HS, 1, "b_hsync_h13");
    ex(d0 + 14, B + HC, 14, "b_h_14"); ex(d0 + 14, B + LS, 0, "b_line_pre");
    ex(d0 + 15, B + HC, 0, "b_wrap_h"); ex(d0 + 15, B + VC, 1, "b_wrap_v");
    ex(d0 + 15, B + LS, 1, "b_line_pulse"); ex(d0 + 15, B + FS, 0, "b_no_frame");
    ex(d0 + 16, B + LS, 0, "b_line_end");
    ex(d0 + 52, B + VAL, 1, "b_valid_v3"); ex(d0 + 60, B + VC, 4, "b_v_4");
    ex(d0 + 60, B + VAL, 0, "b_valid_v4");
    ex(d0 + 74, B + VS, 1, "b_vsync_v4"); ex(d0 + 75, B + VC, 5, "b_v_5");
    ex(d0 + 75, B + VS, 0, "b_vsync_v5"); ex(d0 + 104, B + VS, 0, "b_vsync_v6");
    ex(d0 + 105, B + VC, 7, "b_v_7"); ex(d0 + 105, B + VS, 1, "b_vsync_v7");
    ex(d0 + 119, B + HC, 14, "b_last_h"); ex(d0 + 119, B + VC, 7, "b_last_v");
    ex(d0 + 119, B + FS, 0, "b_frame_pre");
    ex(d0 + 120, B + HC, 0, "b_fwrap_h"); ex(d0 + 120, B + VC, 0, "b_fwrap_v");
    ex(d0 + 120, B + FS, 1, "b_frame_pulse"); ex(d0 + 120, B + LS, 1, "b_frame_line");
    ex(d0 + 120, B + VS, 1, "b_fwrap_vsync"); ex(d0 + 120, B + VAL, 1, "b_fwrap_valid");
    ex(d0 + 121, B + FS, 0, "b_frame_end"); ex(d0 + 121, B + LS, 0, "b_frame_line_end");
    drain();
    ex(-1, C_VSB, 30, "b_vsync_low_clks"); ex(-1, C_LSB, 8, "b_line_pulses");
    ex(-1, C_FSB, 1, "b_frame_pulses");
    fire();

    // Asynchronous reset between edges inside both sync pulses.
    ex(d0 + 206, B + HC, 11, "b_pre_rst_h"); ex(d0 + 206, B + VC, 5, "b_pre_rst_v");
    ex(d0 + 206, B + HS, 0, "b_pre_rst_hsync"); ex(d0 + 206, B + VS, 0, "b_pre_rst_vsync");
    wait_cyc(d0 + 207);
    rst_b = 1'b1;
    #1;
    ex(-1, B + HC, 0, "b_arst_h"); ex(-1, B + VC, 0, "b_arst_v");
    ex(-1, B + HS, 1, "b_arst_hsync"); ex(-1, B + VS, 1, "b_arst_vsync");
    ex(-1, B + VAL, 1, "b_arst_valid"); ex(-1, B + PT, 0, "b_arst_tick");
    ex(-1, B + LS, 0, "b_arst_line"); ex(-1, B + FS, 0, "b_arst_frame");
    fire();
    wait_cyc(d0 + 210);
    rst_b = 1'b0; e0 = cyc;
    ex(e0, B + HC, 0, "b_resume_h0"); ex(e0, B + PT, 1, "b_resume_tick");
    ex(e0, B + LS, 0, "b_resume_line");
    ex(e0 + 1, B + HC, 1, "b_resume_h1"); ex(e0 + 10, B + HS, 0, "b_resume_hsync");
    ex(e0 + 15, B + HC, 0, "b_resume_wrap_h"); ex(e0 + 15, B + VC, 1, "b_resume_wrap_v");
    ex(e0 + 15, B + LS, 1, "b_resume_line_pulse"); ex(e0 + 15, B + FS, 0, "b_resume_no_frame");
    ex(e0 + 16, B + LS, 0, "b_resume_line_end");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
